// File: rtl/distribute_tree_rr_injector.sv
// Round-robin root scheduler for a 1x2 destination-tag distribute tree, with packet-level grant lock.
// Optional o_beat_total accepted-beat counter is enabled by defining DIST_SCHED_BEAT_CNT_EN.
module distribute_tree_rr_injector #(
  parameter int DATA_WIDTH            = 32,
  parameter int DESTINATION_TAG_WIDTH = 3,
  parameter int NUM_REQ               = 4,
  parameter int MAX_BURST             = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_en,
  input  logic [NUM_REQ-1:0]                       i_valid,
  input  logic [NUM_REQ-1:0]                       i_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            i_data_bus,
  input  logic [NUM_REQ*DESTINATION_TAG_WIDTH-1:0] i_dst,
  output logic [NUM_REQ-1:0]                       o_ready,
  output logic                                     o_valid,
  output logic                                     o_en,
  output logic [DATA_WIDTH-1:0]                    o_data_bus,
  output logic [DESTINATION_TAG_WIDTH-1:0]         o_cmd,
  output logic                                     o_busy
`ifdef DIST_SCHED_BEAT_CNT_EN
  ,
  output logic [31:0]                              o_beat_total
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                     state, state_nxt;
  logic [PW-1:0]              rr_ptr, owner, winner, sel;
  logic [CW-1:0]              beat_cnt;
  logic                       win_found, accept, burst_end, pkt_end;
  logic [DATA_WIDTH-1:0]      data_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PW'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    winner    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && i_valid[idx]) begin
        win_found = 1'b1;
        winner    = PW'(idx);
      end
    end
  end

  assign sel       = (state == LOCK) ? owner : winner;
  assign accept    = |(i_valid & o_ready);
  assign burst_end = (state == LOCK) ? (beat_cnt == CW'(MAX_BURST - 1)) : (MAX_BURST == 1);
  assign pkt_end   = i_last[sel] | burst_end;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (!pkt_end) state_nxt = LOCK;
        LOCK:    if (pkt_end)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: grant is withheld entirely under reset or when disabled
  always_comb begin
    o_ready = '0;
    o_busy  = (state == LOCK);
    if (!rst && i_en) begin
      case (state)
        IDLE:    if (win_found) o_ready[winner] = 1'b1;
        LOCK:    o_ready[owner] = 1'b1;
        default: o_ready = '0;
      endcase
    end
  end

  // A single release point covers both i_last and the burst limit, so the pointer advances once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      if (pkt_end) begin
        rr_ptr   <= next_ptr(sel);
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CW'(1);
        if (state == IDLE) owner <= winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_en    <= 1'b0;
      o_cmd   <= '0;
      data_q  <= '0;
    end else begin
      o_valid <= accept;
      o_en    <= accept;
      if (accept) begin
        data_q <= i_data_bus[sel*DATA_WIDTH +: DATA_WIDTH];
        o_cmd  <= i_dst[sel*DESTINATION_TAG_WIDTH +: DESTINATION_TAG_WIDTH];
      end
    end
  end

  assign o_data_bus = o_valid ? data_q : {DATA_WIDTH{1'bz}};

`ifdef DIST_SCHED_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         o_beat_total <= '0;
    else if (accept) o_beat_total <= o_beat_total + 32'd1;
  end
`endif

endmodule

// File: tb/tb_distribute_tree_rr_injector.sv
// Directed bench for distribute_tree_rr_injector: vector table for round-robin/lock, hand sequences for corners.
module tb_distribute_tree_rr_injector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_en;
  logic [3:0]  i_valid, i_last;
  logic [31:0] dat [4];
  logic [2:0]  dst [4];
  logic [127:0] i_data_bus;
  logic [11:0] i_dst;
  logic [3:0]  o_ready;
  logic        o_valid, o_en, o_busy;
  wire  [31:0] o_data_bus;
  logic [2:0]  o_cmd;
`ifdef DIST_SCHED_BEAT_CNT_EN
  logic [31:0] o_beat_total;
`endif

  int total = 0;
  int bad   = 0;

  always_comb begin
    i_data_bus = '0;
    i_dst      = '0;
    for (int k = 0; k < 4; k++) begin
      i_data_bus[k*32 +: 32] = dat[k];
      i_dst[k*3 +: 3]        = dst[k];
    end
  end

  distribute_tree_rr_injector #(
    .DATA_WIDTH(32), .DESTINATION_TAG_WIDTH(3), .NUM_REQ(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_last(i_last),
    .i_data_bus(i_data_bus), .i_dst(i_dst), .o_ready(o_ready), .o_valid(o_valid),
    .o_en(o_en), .o_data_bus(o_data_bus), .o_cmd(o_cmd), .o_busy(o_busy)
`ifdef DIST_SCHED_BEAT_CNT_EN
    , .o_beat_total(o_beat_total)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [3:0] oh);
    for (int k = 0; k < 4; k++) if (oh[k]) return dat[k];
    return 32'h0;
  endfunction

  // Drive one cycle, check the combinational grant, then the registered root outputs after the edge.
  task automatic step(input string nm, input logic r, input logic e, input logic [3:0] v,
                      input logic [3:0] l, input logic [3:0] rdy, input logic ov,
                      input logic [2:0] cmd, input logic busy);
    logic [31:0] ed;
    rst = r; i_en = e; i_valid = v; i_last = l;
    ed = exp_data(rdy);
    #1;
    chk({nm, ".ready"}, 32'(o_ready), 32'(rdy));
    @(posedge clk); #1;
    chk({nm, ".valid"}, 32'(o_valid), 32'(ov));
    chk({nm, ".en"},    32'(o_en),    32'(ov));
    chk({nm, ".cmd"},   32'(o_cmd),   32'(cmd));
    chk({nm, ".busy"},  32'(o_busy),  32'(busy));
    if (ov) chk({nm, ".data"}, o_data_bus, ed);
  endtask

  typedef struct {
    logic       en;
    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] rdy;
    logic       ov;
    logic [2:0] cmd;
    logic       busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    dat[0] = 32'hA000_0000; dat[1] = 32'hA111_1111; dat[2] = 32'hA222_2222; dat[3] = 32'hA333_3333;
    dst[0] = 3'b101; dst[1] = 3'b010; dst[2] = 3'b110; dst[3] = 3'b011;

    // Round-robin with single-beat packets, sparse requests, idle and disabled cycles, then a lock.
    tbl[0]  = '{1'b1, 4'hF,    4'hF,    4'b0001, 1'b1, 3'b101, 1'b0};
    tbl[1]  = '{1'b1, 4'hF,    4'hF,    4'b0010, 1'b1, 3'b010, 1'b0};
    tbl[2]  = '{1'b1, 4'hF,    4'hF,    4'b0100, 1'b1, 3'b110, 1'b0};
    tbl[3]  = '{1'b1, 4'hF,    4'hF,    4'b1000, 1'b1, 3'b011, 1'b0};
    tbl[4]  = '{1'b1, 4'hF,    4'hF,    4'b0001, 1'b1, 3'b101, 1'b0};
    tbl[5]  = '{1'b1, 4'b1010, 4'hF,    4'b0010, 1'b1, 3'b010, 1'b0};
    tbl[6]  = '{1'b1, 4'b0001, 4'hF,    4'b0001, 1'b1, 3'b101, 1'b0};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'b101, 1'b0};
    tbl[8]  = '{1'b0, 4'hF,    4'hF,    4'b0000, 1'b0, 3'b101, 1'b0};
    tbl[9]  = '{1'b1, 4'b0110, 4'b0000, 4'b0010, 1'b1, 3'b010, 1'b1};
    tbl[10] = '{1'b1, 4'b0110, 4'b0000, 4'b0010, 1'b1, 3'b010, 1'b1};
    tbl[11] = '{1'b1, 4'b0110, 4'b0010, 4'b0010, 1'b1, 3'b010, 1'b0};
    tbl[12] = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 3'b110, 1'b0};

    step("reset0", 1'b1, 1'b1, 4'hF, 4'h0, 4'b0000, 1'b0, 3'b000, 1'b0);
    step("reset1", 1'b1, 1'b1, 4'hF, 4'h0, 4'b0000, 1'b0, 3'b000, 1'b0);

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), 1'b0, tbl[i].en, tbl[i].v, tbl[i].l,
           tbl[i].rdy, tbl[i].ov, tbl[i].cmd, tbl[i].busy);

    // req0 never sends last and bubbles once; forced release after 8 beats, then req1 wins.
    for (int b = 1; b <= 8; b++) begin
      if (b == 4) step("bubble", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0001, 1'b0, 3'b101, 1'b1);
      dat[0] = 32'h0B00_0000 + 32'(b);
      step($sformatf("burst%0d", b), 1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b1, 3'b101, b < 8);
    end
    step("after_limit", 1'b0, 1'b1, 4'b0011, 4'b0011, 4'b0010, 1'b1, 3'b010, 1'b0);

    // Enable dropped for 3 cycles mid-lock; the burst still ends exactly at beat 8.
    for (int b = 1; b <= 8; b++) begin
      if (b == 3)
        for (int j = 0; j < 3; j++)
          step($sformatf("en_off%0d", j), 1'b0, 1'b0, 4'b1100, 4'b0000, 4'b0000, 1'b0, 3'b110, 1'b1);
      dat[2] = 32'h0E00_0000 + 32'(b);
      step($sformatf("en_beat%0d", b), 1'b0, 1'b1, 4'b1100, 4'b0000, 4'b0100, 1'b1, 3'b110, b < 8);
    end

    // Reset during beat 2 of a packet from req3; afterwards the search restarts at requester 0.
    step("pre_rst",  1'b0, 1'b1, 4'b1010, 4'b0000, 4'b1000, 1'b1, 3'b011, 1'b1);
    step("mid_rst",  1'b1, 1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0);
    step("post_rst", 1'b0, 1'b1, 4'b1010, 4'b1010, 4'b0010, 1'b1, 3'b010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
